f_pcgen: RTL

- Fetch-stage PC generator for the dual-issue RV32I pipeline. It holds the 13-bit word PC and presents two consecutive fetch slots, pc1 and pc2 = pc1+1.
- A small direct-mapped branch target buffer (BTB) predicts the next PC. The prediction travels down the pipe as pc_predicted, and the D stage compares it against its jal target.
- The block accepts redirects from the D stage (jal mispredict) and the E stage (jalr/branch mispredict), plus BTB training writes.

---
 rtl/f_pcgen.sv | 107 ++++++++++
 1 files changed

// File: rtl/f_pcgen.sv
// Fetch-stage PC generator: holds the word PC, presents two fetch slots and
// predicts the next pc1 from a direct-mapped BTB, with D/E redirect and training.
module f_pcgen #(
   parameter logic [12:0] RESET_PC = 13'h0000,
   parameter int          BTB_IDX  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        d_redirect,
   input  logic [12:0] d_target,
   input  logic        e_redirect,
   input  logic [12:0] e_target,
   input  logic        upd_en,
   input  logic [12:0] upd_pc,
   input  logic [12:0] upd_target,
   output logic [12:0] pc1,
   output logic [12:0] pc2,
   output logic        valid1,
   output logic        valid2,
   output logic [1:0]  pred_taken,
   output logic [12:0] pc_predicted
);

   // state   | meaning
   // --------+---------------------------------------------------------
   // ST_BOOT | out of reset, pc parked at RESET_PC, fetch slots invalid
   // ST_RUN  | fetching; pc advances by prediction, redirect or stall

   localparam int TAG_W = 13 - BTB_IDX;
   localparam int N_ENT = 1 << BTB_IDX;

   typedef enum logic {ST_BOOT, ST_RUN} state_t;

   state_t             state_q, state_nxt;
   logic [12:0]        pc_q, pc_nxt;

   logic [N_ENT-1:0]   btb_vld;
   logic [TAG_W-1:0]   btb_tag [N_ENT];
   logic [12:0]        btb_tgt [N_ENT];

   logic [BTB_IDX-1:0] idx1, idx2, upd_idx;
   logic               hit1, hit2;

   assign pc1     = pc_q;
   assign pc2     = pc_q + 13'd1;
   assign idx1    = pc1[BTB_IDX-1:0];
   assign idx2    = pc2[BTB_IDX-1:0];
   assign upd_idx = upd_pc[BTB_IDX-1:0];

   // Each slot looks up its own entry, so a wrapped pc2 may hit elsewhere.
   assign hit1 = btb_vld[idx1] && (btb_tag[idx1] == pc1[12:BTB_IDX]);
   assign hit2 = btb_vld[idx2] && (btb_tag[idx2] == pc2[12:BTB_IDX]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         btb_vld <= '0;
      end else begin
         state_q <= state_nxt;
         pc_q    <= pc_nxt;
         if (upd_en) btb_vld[upd_idx] <= 1'b1;
      end
   end

   // Tag/target storage needs no reset; the valid bits guard it.
   always_ff @(posedge clk) begin
      if (rst_n && upd_en) begin
         btb_tag[upd_idx] <= upd_pc[12:BTB_IDX];
         btb_tgt[upd_idx] <= upd_target;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      pc_nxt       = pc_q;
      valid1       = 1'b0;
      valid2       = 1'b0;
      pred_taken   = 2'b00;
      pc_predicted = pc_q;
      case (state_q)
         ST_BOOT: begin
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            valid1 = 1'b1;
            if (hit1) begin
               pred_taken   = 2'b01;
               pc_predicted = btb_tgt[idx1];
            end else if (hit2) begin
               pred_taken   = 2'b10;
               pc_predicted = btb_tgt[idx2];
            end else begin
               pc_predicted = pc_q + 13'd2;
            end
            valid2 = ~pred_taken[0];
            // E is older than D, and any redirect beats a stall.
            if (e_redirect)      pc_nxt = e_target;
            else if (d_redirect) pc_nxt = d_target;
            else if (!stall)     pc_nxt = pc_predicted;
         end
         default: state_nxt = ST_BOOT;
      endcase
   end

endmodule
